spi_slave_mode: RTL and testbench
=================================

SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  DATA_W, 8, word width in bits (2..32)
  MSB_FIRST, 1, 1 = MSB shifted first on both mosi and miso, 0 = LSB first
  SYNC_STAGES, 2, synchroniser depth for sclk/cs/mosi (2..3)
REQ-002 Ports SHALL be (one per line: name  direction  width  meaning):
  clk  in  1  system clock, sole clock
  rst  in  1  synchronous, active-high reset
  sclk  in  1  SPI serial clock, asynchronous to clk
  cs  in  1  chip select, active low
  mosi  in  1  serial data in
  miso  out  1  serial data out, driven 0 while deselected (no tri-state)
  mode  in  2  {CPOL,CPHA}, latched at frame start
  tx_data  in  DATA_W  word to transmit
  tx_valid  in  1  tx_data valid
  tx_ready  out  1  tx holding buffer empty
  rx_data  out  DATA_W  last complete received word
  rx_valid  out  1  one-clk pulse, rx_data updated
  tx_underrun  out  1  sticky: a word was loaded with tx buffer empty
  busy  out  1  frame in progress
REQ-003 Clocking: one clock; reset is synchronous and active-high; ports named clk and rst.

Function
REQ-004 sclk, cs, mosi SHALL pass through SYNC_STAGES flops before use; edges of sclk and cs SHALL be detected on the synchronised signals; sclk frequency SHALL be at most clk/8.
REQ-005 FSM states SHALL be IDLE, SHIFT; IDLE->SHIFT on synchronised cs falling edge; SHIFT->IDLE on synchronised cs rising edge; busy=1 exactly in SHIFT.
REQ-006 On IDLE->SHIFT: latch mode; load shift register from tx buffer (all zeros if empty); clear bit counter.
REQ-007 Leading edge = sclk transition away from latched CPOL level; trailing edge = the opposite transition.
REQ-008 CPHA=0: sample mosi on leading edge, shift miso on trailing edge; first bit on miso the cycle after frame start.
REQ-009 CPHA=1: shift miso on leading edge (first leading edge presents first bit), sample mosi on trailing edge.
REQ-010 After DATA_W samples: rx_data <= assembled word, rx_valid=1 for one clk, counter clears, next word loaded from tx buffer (continuous frames without cs toggle).
REQ-011 rx_valid SHALL assert no later than SYNC_STAGES+2 clk cycles after the final sampling sclk edge at the pin.
REQ-012 tx buffer: single entry; accept when tx_valid&&tx_ready; tx_ready=0 while full; emptied by a word load.
REQ-013 Word load with buffer empty: shift zeros, set tx_underrun; word accepted in that same cycle stays buffered for the next load (no bypass).
REQ-014 cs deassert mid-word: abort, discard partial rx, no rx_valid, rx_data unchanged; loaded tx word is lost, buffer untouched.
REQ-015 sclk edges while in IDLE SHALL be ignored.

Reset
REQ-016 Under rst: FSM=IDLE, shift reg/counter=0, miso=0, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, tx buffer empty (tx_ready=1).
REQ-017 rst mid-frame aborts per REQ-014; if cs still low after release, block waits for the next cs falling edge.

Structure
REQ-018 Package spi_pkg SHALL hold the FSM state encoding and CPOL/CPHA bit-index constants.
REQ-019 Sub-module spi_sync (SYNC_STAGES flop chain + rise/fall pulse outputs) SHALL be instantiated for sclk and cs; mosi uses the chain only.

Verification
REQ-020 Mode 0, DATA_W=8, tx 0xA5 buffered, master sends 0x5A -> rx_data=0x5A, one rx_valid, miso bits 1,0,1,0,0,1,0,1.
REQ-021 Mode 3, same data -> identical results, sampling on rising sclk; mode 1/2 spot-check one word each.
REQ-022 MSB_FIRST=0, tx 0x01, mosi 0x80 sent LSB first -> miso first bit 1, rx_data=0x80.
REQ-023 Two back-to-back words, cs held low, tx 0x11 then 0x22 refilled mid-word -> rx_valid twice, miso 0x11 then 0x22, tx_underrun=0; third word unfilled -> miso zeros, tx_underrun=1.
REQ-024 cs raised after 4 bits -> no rx_valid, rx_data unchanged; next full frame 0xC3 -> rx_data=0xC3.
REQ-025 rst asserted mid-frame with cs low -> all outputs at reset values, no activity until cs high then low again.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   spi_state_e : frame FSM encoding (IDLE between frames, SHIFT while selected)
//   CPOL_BIT    : index of CPOL inside the 2-bit {CPOL,CPHA} mode word
//   CPHA_BIT    : index of CPHA inside the 2-bit {CPOL,CPHA} mode word
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_slave_mode_if.sv
// Bundle of the SPI pins plus the parallel tx/rx side of the slave.
//   slave  modport : view of the SPI slave (drives miso and the rx/status side)
//   master modport : view of whatever drives the pins and the tx word stream
interface spi_slave_mode_if #(
  parameter int DATA_W = 8
);

  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [1:0]        mode;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs, mosi, mode, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs, mosi, mode, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Synchroniser with edge detection for one asynchronous input.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised level (STAGES flops deep)
//   rise     : one-clk pulse when q goes 0 -> 1
//   fall     : one-clk pulse when q goes 1 -> 0
// All flops reset to 0.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise =  q & ~q_d;
  assign fall = ~q &  q_d;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave supporting all four {CPOL,CPHA} modes, selected per frame.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_slave_mode_if.slave
//              sclk/cs/mosi  asynchronous SPI inputs (sclk <= clk/8)
//              miso          registered, 0 while deselected
//              mode          {CPOL,CPHA}, latched on cs falling edge
//              tx_data/valid/ready  single-entry transmit buffer
//              rx_data/valid        last complete word, one-clk strobe
//              tx_underrun          sticky, word loaded from an empty buffer
//              busy                 frame in progress
// Words run back to back while cs stays low; a cs rise mid-word discards it.
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_slave_mode_if.slave     bus
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  // The FSM acts on edges only; the synchronised levels are not needed.
  logic sclk_lvl_unused, cs_lvl_unused;

  // The cs chain resets to the "selected" level so that a cs held low across
  // reset produces no falling edge: the slave waits for a fresh select.
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (bus.sclk),
    .q (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk), .rst (rst), .d (bus.cs),
    .q (cs_lvl_unused), .rise (cs_rise), .fall (cs_fall)
  );

  // mosi needs the same latency as sclk so a sample edge sees the matching bit.
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;

  always_ff @(posedge clk) begin
    if (rst) mosi_chain <= '0;
    else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.mosi};
  end

  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  spi_state_e        state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_buf, rx_data_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              miso_q, rx_valid_q, tx_full, underrun_q;

  logic              lead, trail, sample_edge, present_edge, word_done;
  logic              word_load, tx_accept, cur_bit, load_bit;
  logic [DATA_W-1:0] rx_next, load_word, tx_sr_sh, load_sh;

  // NOTE: every signal of this block is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    // Leading edge leaves the CPOL idle level, trailing edge returns to it.
    lead         = mode_q[CPOL_BIT] ? sclk_fall : sclk_rise;
    trail        = mode_q[CPOL_BIT] ? sclk_rise : sclk_fall;
    sample_edge  = mode_q[CPHA_BIT] ? trail : lead;
    present_edge = mode_q[CPHA_BIT] ? lead  : trail;
    word_done    = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));

    rx_next   = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
    load_word = tx_full ? tx_buf : '0;
    cur_bit   = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
    load_bit  = MSB_FIRST ? load_word[DATA_W-1] : load_word[0];
    tx_sr_sh  = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    load_sh   = MSB_FIRST ? {load_word[DATA_W-2:0], 1'b0} : {1'b0, load_word[DATA_W-1:1]};

    tx_accept = bus.tx_valid && !tx_full;
    word_load = ((state == IDLE) && cs_fall) ||
                ((state == SHIFT) && !cs_rise && word_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            mode_q  <= bus.mode;
            bit_cnt <= '0;
            rx_sr   <= '0;
            // CPHA=0 must present bit 0 before the first leading edge;
            // CPHA=1 presents it on that edge instead.
            if (!bus.mode[CPHA_BIT]) begin
              miso_q <= load_bit;
              tx_sr  <= load_sh;
            end else begin
              tx_sr  <= load_word;
            end
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // Abort: partial word is dropped, the loaded tx word is lost.
            state   <= IDLE;
            miso_q  <= 1'b0;
            bit_cnt <= '0;
            rx_sr   <= '0;
          end else begin
            if (present_edge) begin
              miso_q <= cur_bit;
              tx_sr  <= tx_sr_sh;
            end
            if (sample_edge) begin
              if (word_done) begin
                // The next word's first bit goes out on the next present edge.
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                rx_sr      <= '0;
                bit_cnt    <= '0;
                tx_sr      <= load_word;
              end else begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
      endcase

      // A load empties the buffer; a word accepted in the same cycle is kept
      // for the following load rather than bypassed into the shifter.
      if (word_load) begin
        tx_full <= tx_accept;
        if (!tx_full) underrun_q <= 1'b1;
      end else if (tx_accept) begin
        tx_full <= 1'b1;
      end
      if (tx_accept) tx_buf <= bus.tx_data;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench for spi_slave_mode: an MSB-first and an LSB-first instance
// share the SPI pins; each has its own tx stream.
module tb_spi_slave_mode;

  localparam int HALF = 50;  // sclk half period: 5 clk cycles

  logic       clk, rst;
  logic       sclk, cs, mosi;
  logic [1:0] mode;
  logic [7:0] tx_data_m, tx_data_l;
  logic       tx_valid_m, tx_valid_l;
  logic       lsb;
  logic [7:0] got_m, got_l;
  int         rxv_m, rxv_l, snap_m, snap_l;
  int         errors, checks;

  spi_slave_mode_if #(.DATA_W(8)) bus_m ();
  spi_slave_mode_if #(.DATA_W(8)) bus_l ();

  assign bus_m.sclk = sclk;  assign bus_l.sclk = sclk;
  assign bus_m.cs   = cs;    assign bus_l.cs   = cs;
  assign bus_m.mosi = mosi;  assign bus_l.mosi = mosi;
  assign bus_m.mode = mode;  assign bus_l.mode = mode;
  assign bus_m.tx_data  = tx_data_m;
  assign bus_m.tx_valid = tx_valid_m;
  assign bus_l.tx_data  = tx_data_l;
  assign bus_l.tx_valid = tx_valid_l;

  spi_slave_mode #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_m (
    .clk (clk), .rst (rst), .bus (bus_m)
  );

  spi_slave_mode #(.DATA_W(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_l (
    .clk (clk), .rst (rst), .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rx_valid is a one-clk pulse, so each pulse is seen by exactly one negedge.
  always @(negedge clk) begin
    if (bus_m.rx_valid) rxv_m++;
    if (bus_l.rx_valid) rxv_l++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input bit to_l, input logic [7:0] d);
    @(negedge clk);
    if (to_l) begin tx_data_l = d; tx_valid_l = 1'b1; end
    else      begin tx_data_m = d; tx_valid_m = 1'b1; end
    @(negedge clk);
    tx_valid_l = 1'b0;
    tx_valid_m = 1'b0;
  endtask

  // Master side of bits first..last of one word; miso is captured just
  // before the master's sampling edge into got_m (MSB first) / got_l (LSB first).
  task automatic xfer(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      if (!mode[0]) begin
        mosi = w[idx];
        #HALF;
        got_m[7-i] = bus_m.miso;
        got_l[i]   = bus_l.miso;
        sclk = ~mode[1];
        #HALF;
        sclk = mode[1];
      end else begin
        sclk = ~mode[1];
        mosi = w[idx];
        #HALF;
        got_m[7-i] = bus_m.miso;
        got_l[i]   = bus_l.miso;
        sclk = mode[1];
        #HALF;
      end
    end
  endtask

  task automatic begin_frame();
    snap_m = rxv_m;
    snap_l = rxv_l;
    got_m  = '0;
    got_l  = '0;
    cs = 1'b0;
    #(2*HALF);
  endtask

  task automatic end_frame();
    #HALF;
    cs = 1'b1;
    #(2*HALF);
  endtask

  initial begin
    errors = 0; checks = 0; rxv_m = 0; rxv_l = 0;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; mode = 2'b00; lsb = 1'b0;
    tx_data_m = '0; tx_data_l = '0; tx_valid_m = 1'b0; tx_valid_l = 1'b0;
    got_m = '0; got_l = '0;
    repeat (5) @(negedge clk);

    // Reset values
    check("rst_miso", bus_m.miso, 1'b0);
    check("rst_tx_ready", bus_m.tx_ready, 1'b1);
    check("rst_rx_data", bus_m.rx_data, 8'h00);
    check("rst_rx_valid", bus_m.rx_valid, 1'b0);
    check("rst_underrun", bus_m.tx_underrun, 1'b0);
    check("rst_busy", bus_m.busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back words, refill during the first word, then starve
    push(1'b0, 8'h11);
    check("b2b_tx_full", bus_m.tx_ready, 1'b0);
    begin_frame();
    xfer(8'h3C, 0, 3);
    push(1'b0, 8'h22);
    check("b2b_refill_full", bus_m.tx_ready, 1'b0);
    xfer(8'h3C, 4, 7);
    check("b2b_w1_miso", got_m, 8'h11);
    check("b2b_w1_rx", bus_m.rx_data, 8'h3C);
    check("b2b_w1_rxv", rxv_m - snap_m, 1);
    check("b2b_w1_loaded", bus_m.tx_ready, 1'b1);
    got_m = '0;
    xfer(8'h96, 0, 3);
    check("b2b_w2_underrun", bus_m.tx_underrun, 1'b0);
    xfer(8'h96, 4, 7);
    check("b2b_w2_miso", got_m, 8'h22);
    check("b2b_w2_rx", bus_m.rx_data, 8'h96);
    check("b2b_w2_rxv", rxv_m - snap_m, 2);
    got_m = '0;
    xfer(8'h0F, 0, 7);
    check("b2b_w3_miso", got_m, 8'h00);
    check("b2b_w3_underrun", bus_m.tx_underrun, 1'b1);
    check("b2b_w3_rx", bus_m.rx_data, 8'h0F);
    check("b2b_w3_rxv", rxv_m - snap_m, 3);
    end_frame();

    // Mode 0 single word
    push(1'b0, 8'hA5);
    begin_frame();
    check("m0_busy", bus_m.busy, 1'b1);
    xfer(8'h5A, 0, 7);
    check("m0_miso", got_m, 8'hA5);
    check("m0_rx", bus_m.rx_data, 8'h5A);
    check("m0_rxv", rxv_m - snap_m, 1);
    end_frame();
    check("m0_idle_busy", bus_m.busy, 1'b0);
    check("m0_idle_miso", bus_m.miso, 1'b0);

    // Mode 3: sclk idles high (edge while idle must be ignored)
    mode = 2'b11; sclk = 1'b1;
    #(2*HALF);
    push(1'b0, 8'hA5);
    begin_frame();
    xfer(8'h5A, 0, 7);
    check("m3_miso", got_m, 8'hA5);
    check("m3_rx", bus_m.rx_data, 8'h5A);
    check("m3_rxv", rxv_m - snap_m, 1);
    end_frame();

    // Mode 1
    mode = 2'b01; sclk = 1'b0;
    #(2*HALF);
    push(1'b0, 8'h69);
    begin_frame();
    xfer(8'h96, 0, 7);
    check("m1_miso", got_m, 8'h69);
    check("m1_rx", bus_m.rx_data, 8'h96);
    check("m1_rxv", rxv_m - snap_m, 1);
    end_frame();

    // Mode 2
    mode = 2'b10; sclk = 1'b1;
    #(2*HALF);
    push(1'b0, 8'hF0);
    begin_frame();
    xfer(8'h0F, 0, 7);
    check("m2_miso", got_m, 8'hF0);
    check("m2_rx", bus_m.rx_data, 8'h0F);
    check("m2_rxv", rxv_m - snap_m, 1);
    end_frame();

    // Abort after 4 bits; buffer refilled mid-frame must survive the abort
    mode = 2'b00; sclk = 1'b0;
    #(2*HALF);
    push(1'b0, 8'h55);
    begin_frame();
    xfer(8'hFF, 0, 1);
    push(1'b0, 8'h33);
    xfer(8'hFF, 2, 3);
    end_frame();
    check("abort_rxv", rxv_m - snap_m, 0);
    check("abort_rx_kept", bus_m.rx_data, 8'h0F);
    check("abort_busy", bus_m.busy, 1'b0);
    check("abort_buf_kept", bus_m.tx_ready, 1'b0);
    begin_frame();
    xfer(8'hC3, 0, 7);
    check("after_abort_miso", got_m, 8'h33);
    check("after_abort_rx", bus_m.rx_data, 8'hC3);
    check("after_abort_rxv", rxv_m - snap_m, 1);
    end_frame();

    // LSB-first instance
    lsb = 1'b1;
    push(1'b1, 8'h01);
    begin_frame();
    xfer(8'h80, 0, 7);
    check("lsb_first_bit", got_l[0], 1'b1);
    check("lsb_miso", got_l, 8'h01);
    check("lsb_rx", bus_l.rx_data, 8'h80);
    check("lsb_rxv", rxv_l - snap_l, 1);
    end_frame();
    lsb = 1'b0;

    // Reset mid-frame with cs held low
    push(1'b0, 8'h77);
    begin_frame();
    xfer(8'hAA, 0, 2);
    push(1'b0, 8'h99);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mrst_busy", bus_m.busy, 1'b0);
    check("mrst_miso", bus_m.miso, 1'b0);
    check("mrst_rx", bus_m.rx_data, 8'h00);
    check("mrst_underrun", bus_m.tx_underrun, 1'b0);
    check("mrst_tx_ready", bus_m.tx_ready, 1'b1);
    snap_m = rxv_m;
    got_m  = '0;
    xfer(8'hAA, 0, 7);
    #HALF;
    check("mrst_ignore_rxv", rxv_m - snap_m, 0);
    check("mrst_ignore_busy", bus_m.busy, 1'b0);
    check("mrst_ignore_miso", got_m, 8'h00);
    check("mrst_ignore_rx", bus_m.rx_data, 8'h00);
    cs = 1'b1;
    #(2*HALF);
    push(1'b0, 8'hE7);
    begin_frame();
    check("mrst_new_busy", bus_m.busy, 1'b1);
    xfer(8'h18, 0, 7);
    check("mrst_new_miso", got_m, 8'hE7);
    check("mrst_new_rx", bus_m.rx_data, 8'h18);
    check("mrst_new_rxv", rxv_m - snap_m, 1);
    end_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
